// File: rtl/iopmp_error_recorder_q.sv
// iopmp_error_recorder_q
// Queued multi-channel IOPMP error capture. Violation reports from the checker
// channels are arbitrated round-robin. The oldest accepted report sits in the
// architectural error record; later ones wait in a small FIFO. A software clear
// of the record promotes the next queued report. Reports that arrive with no
// room are consumed and dropped, and a sticky overflow flag records that.
//
// Optional build macro: IOPMP_ERR_CNT_EN adds cnt_clr_i / err_cnt_o, a 16-bit
// saturating count of every qualified report consumed (recorded or dropped).
//
// Handshake: a channel presents a report by holding err_valid_i high with a
// non-zero ttype. The report is consumed in any cycle where err_valid_i and
// err_ready_o are both high at the clock edge. A channel that sees ready low
// must keep the same report on its inputs. Channels with ttype==0 are ignored
// and never see ready.

module iopmp_error_recorder_q #(
  parameter int IOPMPNumChan = 2,
  parameter int FifoDepth    = 4,
  parameter int AddrWidth    = 64,
  parameter int RidWidth     = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [IOPMPNumChan-1:0]           err_valid_i,
  input  logic [2*IOPMPNumChan-1:0]         err_ttype_i,
  input  logic [4*IOPMPNumChan-1:0]         err_etype_i,
  input  logic [AddrWidth*IOPMPNumChan-1:0] err_addr_i,
  input  logic [RidWidth*IOPMPNumChan-1:0]  err_rrid_i,
  output logic [IOPMPNumChan-1:0]           err_ready_o,
  input  logic                              clr_i,
  input  logic                              ovf_clr_i,
  input  logic                              ie_i,
`ifdef IOPMP_ERR_CNT_EN
  input  logic                              cnt_clr_i,
  output logic [15:0]                       err_cnt_o,
`endif
  output logic                              rec_v_o,
  output logic [1:0]                        rec_ttype_o,
  output logic [3:0]                        rec_etype_o,
  output logic [AddrWidth-1:0]              rec_addr_o,
  output logic [RidWidth-1:0]               rec_rrid_o,
  output logic                              rec_ovf_o,
  output logic [$clog2(FifoDepth+1)-1:0]    pending_o,
  output logic                              irq_o
);

  localparam int ChW  = (IOPMPNumChan > 1) ? $clog2(IOPMPNumChan) : 1;
  localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int CntW = $clog2(FifoDepth + 1);
  localparam int NcW  = $clog2(IOPMPNumChan + 1);

  typedef struct packed {
    logic [1:0]           ttype;
    logic [3:0]           etype;
    logic [AddrWidth-1:0] addr;
    logic [RidWidth-1:0]  rrid;
  } rec_t;

  // Architectural record
  rec_t            rec_q, rec_d;
  logic            rec_v_q, rec_v_d;
  logic            ovf_q, ovf_d;

  // Pending queue behind the record
  rec_t            fifo_q [FifoDepth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Round-robin start channel (searched first on the next grant)
  logic [ChW-1:0]  rr_q, rr_d;

  // Arbitration and datapath signals
  logic [IOPMPNumChan-1:0] req;
  logic [IOPMPNumChan-1:0] gnt_oh;
  logic [ChW-1:0]          gnt_idx;
  logic [ChW-1:0]          cand_idx;
  int                      cand;
  logic                    gnt_found;
  rec_t                    gnt_rec;
  logic                    fifo_full, fifo_empty;
  logic                    space;
  logic                    accept;
  logic                    drop;
  logic                    rec_clr;
  logic                    load_direct;
  logic                    push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(FifoDepth - 1)) return '0;
    return p + 1'b1;
  endfunction

  function automatic logic [ChW-1:0] ch_inc(input logic [ChW-1:0] c);
    if (c == ChW'(IOPMPNumChan - 1)) return '0;
    return c + 1'b1;
  endfunction

  // A channel requests only when valid with a non-reserved transaction type
  always_comb begin
    req = '0;
    for (int c = 0; c < IOPMPNumChan; c++) begin
      req[c] = err_valid_i[c] & (err_ttype_i[2*c +: 2] != 2'b00);
    end
  end

  assign fifo_full  = (cnt_q == CntW'(FifoDepth));
  assign fifo_empty = (cnt_q == '0);
  assign rec_clr    = clr_i & rec_v_q;
  assign space      = ~rec_v_q | ~fifo_full | rec_clr;

  // Round-robin search starting at rr_q; at most one winner
  always_comb begin
    gnt_oh    = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < IOPMPNumChan; k++) begin
      cand = int'(rr_q) + k;
      if (cand >= IOPMPNumChan) cand = cand - IOPMPNumChan;
      cand_idx = ChW'(cand);
      if (!gnt_found && req[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
    if (gnt_found) gnt_oh[gnt_idx] = 1'b1;
  end

  // Select the granted channel's report fields
  always_comb begin
    gnt_rec = '0;
    for (int c = 0; c < IOPMPNumChan; c++) begin
      if (gnt_oh[c]) begin
        gnt_rec.ttype = err_ttype_i[2*c +: 2];
        gnt_rec.etype = err_etype_i[4*c +: 4];
        gnt_rec.addr  = err_addr_i[AddrWidth*c +: AddrWidth];
        gnt_rec.rrid  = err_rrid_i[RidWidth*c +: RidWidth];
      end
    end
  end

  // With room only the winner is consumed; without room every requester is
  // consumed and its report discarded.
  assign err_ready_o = rst_i ? '0 : (space ? gnt_oh : req);
  assign accept      = ~rst_i & space & gnt_found;
  assign drop        = ~rst_i & ~space & (|req);

  // Record is loaded directly only when nothing older is waiting
  assign load_direct = accept & fifo_empty & (~rec_v_q | rec_clr);
  assign push        = accept & ~load_direct;
  assign pop         = rec_clr & ~fifo_empty;

  // Next-state for record, queue bookkeeping, overflow flag and RR pointer
  always_comb begin
    rec_d    = rec_q;
    rec_v_d  = rec_v_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    rr_d     = rr_q;

    if (pop) begin
      rec_d   = fifo_q[rd_ptr_q];
      rec_v_d = 1'b1;
    end else if (load_direct) begin
      rec_d   = gnt_rec;
      rec_v_d = 1'b1;
    end else if (rec_clr) begin
      rec_v_d = 1'b0;
    end

    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase

    // A drop in the same cycle as a software clear keeps the flag set
    if (ovf_clr_i) ovf_d = 1'b0;
    if (drop)      ovf_d = 1'b1;

    if (accept) rr_d = ch_inc(gnt_idx);
  end

  // Control and record registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rec_q    <= '0;
      rec_v_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      rr_q     <= '0;
    end else begin
      rec_q    <= rec_d;
      rec_v_q  <= rec_v_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      rr_q     <= rr_d;
    end
  end

  // Queue storage; contents are only meaningful between the pointers
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= gnt_rec;
  end

`ifdef IOPMP_ERR_CNT_EN
  logic [15:0]    err_cnt_q, err_cnt_d;
  logic [NcW-1:0] n_cons;
  logic [16:0]    cnt_sum;

  // Count consumed qualified reports, saturating; clear beats increment
  always_comb begin
    n_cons = '0;
    for (int c = 0; c < IOPMPNumChan; c++) begin
      n_cons = n_cons + NcW'(err_ready_o[c]);
    end
    cnt_sum = {1'b0, err_cnt_q} + 17'(n_cons);
    if (cnt_clr_i)       err_cnt_d = '0;
    else if (cnt_sum[16]) err_cnt_d = 16'hFFFF;
    else                 err_cnt_d = cnt_sum[15:0];
  end

  // Error counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;
`endif

  assign rec_v_o     = rec_v_q;
  assign rec_ttype_o = rec_q.ttype;
  assign rec_etype_o = rec_q.etype;
  assign rec_addr_o  = rec_q.addr;
  assign rec_rrid_o  = rec_q.rrid;
  assign rec_ovf_o   = ovf_q;
  assign pending_o   = cnt_q;
  assign irq_o       = rec_v_q & ie_i;

endmodule
